// File: rtl/inst_rom_resp_pkg.sv
// Shared fetch-side definitions: bus widths, enable levels, responder states, address check.
// Used by inst_rom_resp and inst_rom_array.
package inst_rom_resp_pkg;

  localparam int   INST_ADDR_W  = 32;
  localparam int   INST_W       = 32;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    INST_ROM_IDLE = 2'd0,
    INST_ROM_WAIT = 2'd1,
    INST_ROM_RESP = 2'd2
  } inst_rom_state_e;

  // A fetch is bad when it is not word aligned or lands beyond the ROM.
  function automatic logic addr_is_err(input logic [INST_ADDR_W-1:0] addr, input int depth_log2);
    logic [INST_ADDR_W-1:0] hi;
    hi = addr >> (depth_log2 + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Instruction storage, 2^DEPTH_LOG2 x 32, synchronous read; read data holds between enables.
// One-cycle read latency, no flow control.
module inst_rom_array
  import inst_rom_resp_pkg::*;
#(
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = "inst_rom.data"
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [INST_W-1:0]     rd_data
);

  logic [INST_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [INST_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_rom_resp.sv
// Fetch responder: request at edge N -> registered inst_valid after edge N+1+WAIT_CYCLES; stall_req while waiting.
// Optional fetch_cnt output when INST_ROM_FETCH_CNT_EN is defined.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = "inst_rom.data"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  output logic [INST_W-1:0]      inst,
  output logic                   inst_valid,
  output logic                   stall_req,
  output logic                   addr_err
`ifdef INST_ROM_FETCH_CNT_EN
  ,
  output logic [31:0]            fetch_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  inst_rom_state_e        state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   addr_err_q, addr_err_d;
  logic                   accept;
  logic [INST_W-1:0]      rom_rdata;

  // The array read launches on the accept edge; its output is held until RESP.
  inst_rom_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (addr[DEPTH_LOG2+1:2]),
    .rd_data (rom_rdata)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    addr_err_d   = addr_err_q;
    accept       = 1'b0;

    case (state_q)
      INST_ROM_IDLE: begin
        accept = (ce == CHIP_ENABLE);
      end
      INST_ROM_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) state_d = INST_ROM_RESP;
      end
      INST_ROM_RESP: begin
        inst_valid_d = 1'b1;
        addr_err_d   = addr_is_err(addr_q, DEPTH_LOG2);
        inst_d       = addr_err_d ? '0 : rom_rdata;
        state_d      = INST_ROM_IDLE;
        accept       = (ce == CHIP_ENABLE);
      end
      default: begin
        state_d = INST_ROM_IDLE;
      end
    endcase

    // Back-to-back accept from RESP behaves exactly like an accept from IDLE.
    if (accept) begin
      addr_d     = addr;
      wait_cnt_d = '0;
      state_d    = (WAIT_CYCLES > 0) ? INST_ROM_WAIT : INST_ROM_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q      <= INST_ROM_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign stall_req  = (state_q == INST_ROM_WAIT);

`ifdef INST_ROM_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (inst_valid_d) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) fetch_cnt_q <= '0;
    else                   fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: three instances (WAIT_CYCLES 0, 2, 3) checked against a timing/queue model.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic        ce_v    [3];
  logic [31:0] addr_v  [3];
  logic [31:0] inst_o  [3];
  logic        valid_o [3];
  logic        stall_o [3];
  logic        err_o   [3];
`ifdef INST_ROM_FETCH_CNT_EN
  logic [31:0] fcnt_o  [3];
`endif

  always #5 clk = ~clk;

  inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .INIT_FILE("")) d0 (
    .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .addr(addr_v[0]), .inst(inst_o[0]),
    .inst_valid(valid_o[0]), .stall_req(stall_o[0]), .addr_err(err_o[0])
`ifdef INST_ROM_FETCH_CNT_EN
    , .fetch_cnt(fcnt_o[0])
`endif
  );
  inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .INIT_FILE("")) d1 (
    .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .addr(addr_v[1]), .inst(inst_o[1]),
    .inst_valid(valid_o[1]), .stall_req(stall_o[1]), .addr_err(err_o[1])
`ifdef INST_ROM_FETCH_CNT_EN
    , .fetch_cnt(fcnt_o[1])
`endif
  );
  inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3), .INIT_FILE("")) d2 (
    .clk(clk), .rst(rst_v[2]), .ce(ce_v[2]), .addr(addr_v[2]), .inst(inst_o[2]),
    .inst_valid(valid_o[2]), .stall_req(stall_o[2]), .addr_err(err_o[2])
`ifdef INST_ROM_FETCH_CNT_EN
    , .fetch_cnt(fcnt_o[2])
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] img(input int i);
    if (i == 0) return 32'h3401_1100;
    if (i == 1) return 32'h3402_0020;
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Expected response for a byte address, from the plain addressing rules.
  function automatic bit exp_err(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'd4096);
  endfunction
  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return exp_err(a) ? 32'h0 : img(int'(a / 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: each accepted fetch owns the responder until its response edge.
  int          ec = 0;
  int          ready_e [3];
  int          resp_e  [3];
  bit          pend    [3];
  logic [31:0] p_inst  [3];
  bit          p_err   [3];
  bit          e_valid [3];
  bit          e_stall [3];
  logic [31:0] e_inst  [3];
  bit          e_err   [3];
  logic [31:0] e_cnt   [3];

  task automatic model_edge();
    ec++;
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k]) begin
        pend[k] = 0; ready_e[k] = ec + 1; e_valid[k] = 0; e_stall[k] = 0;
        e_inst[k] = 32'h0; e_err[k] = 0; e_cnt[k] = 32'h0;
      end else begin
        e_valid[k] = pend[k] && (resp_e[k] == ec);
        if (e_valid[k]) begin
          e_inst[k] = p_inst[k]; e_err[k] = p_err[k]; pend[k] = 0; e_cnt[k]++;
        end
        if (ce_v[k] && ec >= ready_e[k]) begin
          pend[k] = 1;
          resp_e[k] = ec + 1 + wait_of(k);
          ready_e[k] = resp_e[k];
          p_inst[k] = exp_inst(addr_v[k]);
          p_err[k] = exp_err(addr_v[k]);
        end
        e_stall[k] = pend[k] && (ec <= resp_e[k] - 2);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d.inst_valid@%0d", k, ec), {31'b0, valid_o[k]}, {31'b0, e_valid[k]});
      chk($sformatf("d%0d.stall_req@%0d", k, ec), {31'b0, stall_o[k]}, {31'b0, e_stall[k]});
      chk($sformatf("d%0d.inst@%0d", k, ec), inst_o[k], e_inst[k]);
      if (e_valid[k]) chk($sformatf("d%0d.addr_err@%0d", k, ec), {31'b0, err_o[k]}, {31'b0, e_err[k]});
`ifdef INST_ROM_FETCH_CNT_EN
      chk($sformatf("d%0d.fetch_cnt@%0d", k, ec), fcnt_o[k], e_cnt[k]);
`endif
    end
  endtask

  // Inputs change at negedge; the model samples them at posedge; outputs are checked at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int stall_cnt;
    bit got_valid;
    int vcount;

    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; ce_v[k] = 1'b0; addr_v[k] = 32'h0; ready_e[k] = 0; pend[k] = 0;
    end
    for (int i = 0; i < 1024; i++) begin
      d0.u_array.mem[i] = img(i);
      d1.u_array.mem[i] = img(i);
      d2.u_array.mem[i] = img(i);
    end

    vecs[0] = '{32'h0000_0000, 32'h3401_1100, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h3402_0020, 1'b0};
    vecs[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0008, img(2),        1'b0};
    vecs[5] = '{32'h0000_0FFC, img(1023),     1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0001, 32'h0000_0000, 1'b1};

    // Reset state
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset d%0d valid", k), {31'b0, valid_o[k]}, 32'h0);
      chk($sformatf("reset d%0d inst", k), inst_o[k], 32'h0);
      chk($sformatf("reset d%0d addr_err", k), {31'b0, err_o[k]}, 32'h0);
      chk($sformatf("reset d%0d stall", k), {31'b0, stall_o[k]}, 32'h0);
      rst_v[k] = 1'b0;
    end
    cycle();

    // Table: single fetches on the zero-wait instance
    for (int v = 0; v < 8; v++) begin
      ce_v[0] = 1'b1; addr_v[0] = vecs[v].addr;
      cycle();
      ce_v[0] = 1'b0;
      cycle();
      chk($sformatf("vec%0d valid", v), {31'b0, valid_o[0]}, 32'h1);
      chk($sformatf("vec%0d inst", v), inst_o[0], vecs[v].inst);
      chk($sformatf("vec%0d addr_err", v), {31'b0, err_o[0]}, {31'b0, vecs[v].err});
    end

    // Back-to-back, zero wait
    ce_v[0] = 1'b1; addr_v[0] = 32'h0;
    cycle();
    addr_v[0] = 32'h4;
    cycle();
    chk("b2b first valid", {31'b0, valid_o[0]}, 32'h1);
    chk("b2b first inst", inst_o[0], 32'h3401_1100);
    chk("b2b stall", {31'b0, stall_o[0]}, 32'h0);
    ce_v[0] = 1'b0;
    cycle();
    chk("b2b second valid", {31'b0, valid_o[0]}, 32'h1);
    chk("b2b second inst", inst_o[0], 32'h3402_0020);
    cycle();
    chk("b2b idle after", {31'b0, valid_o[0]}, 32'h0);

    // Two wait states, single pulse at addr 8
    ce_v[1] = 1'b1; addr_v[1] = 32'h8;
    cycle();
    ce_v[1] = 1'b0;
    stall_cnt = 0; got_valid = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall_o[1]) stall_cnt++;
      if (valid_o[1]) begin got_valid = 1; break; end
      cycle();
    end
    chk("w2 stall cycles", stall_cnt, 32'd2);
    chk("w2 valid seen", {31'b0, got_valid}, 32'h1);
    chk("w2 inst", inst_o[1], img(2));

    // Three wait states, reset during the second wait cycle
    ce_v[2] = 1'b1; addr_v[2] = 32'hC;
    cycle();
    ce_v[2] = 1'b0;
    cycle();
    chk("w3 in wait", {31'b0, stall_o[2]}, 32'h1);
    rst_v[2] = 1'b1;
    cycle();
    chk("w3 rst valid", {31'b0, valid_o[2]}, 32'h0);
    chk("w3 rst stall", {31'b0, stall_o[2]}, 32'h0);
    chk("w3 rst inst", inst_o[2], 32'h0);
    chk("w3 rst addr_err", {31'b0, err_o[2]}, 32'h0);
    rst_v[2] = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (valid_o[2]) vcount++;
    end
    chk("w3 aborted no valid", vcount, 32'd0);
    ce_v[2] = 1'b1; addr_v[2] = 32'h4;
    cycle();
    ce_v[2] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("w3 after rst valid", {31'b0, valid_o[2]}, 32'h1);
    chk("w3 after rst inst", inst_o[2], 32'h3402_0020);

`ifdef INST_ROM_FETCH_CNT_EN
    rst_v[0] = 1'b1;
    cycle();
    rst_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ce_v[0] = 1'b1; addr_v[0] = (i == 2) ? 32'h6 : 32'(i * 4);
      cycle();
    end
    ce_v[0] = 1'b0;
    cycle();
    cycle();
    chk("fetch_cnt five", fcnt_o[0], 32'd5);
    rst_v[0] = 1'b1;
    cycle();
    rst_v[0] = 1'b0;
    chk("fetch_cnt reset", fcnt_o[0], 32'd0);
`endif

    // Random traffic on all instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        int r;
        rst_v[k] = ($urandom_range(0, 99) == 0);
        ce_v[k] = $urandom_range(0, 1) == 1;
        r = $urandom_range(0, 9);
        if (r < 6)      addr_v[k] = 32'($urandom_range(0, 1023)) * 4;
        else if (r < 8) addr_v[k] = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
        else if (r < 9) addr_v[k] = 32'h1000 + 32'($urandom_range(0, 4095)) * 4;
        else            addr_v[k] = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
